// File: rtl/mttkrp_pkg.sv
// Shared types for the MTTKRP factor-fetch path.
// Holds the arbiter state encoding and the compute-id width helper.
package mttkrp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // One extra bit so the value NCU can mean "no unit".
    function automatic int cid_width(input int ncu);
        return $clog2(ncu) + 1;
    endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// In-order FIFO of compute-unit tags for fetches that are in flight.
// Synchronous active-low reset clears the pointers; storage is not reset.
module fetch_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_cnt == CW'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign count  = r_cnt;
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            if (w_push & ~w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (w_pop & ~w_push)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/factor_fetch_arbiter.sv
// Round-robin arbiter issuing factor-row fetches and routing returns by tag.
// Optional perf counters are built when FETCH_ARB_PERF_CNT_EN is defined.
module factor_fetch_arbiter
    import mttkrp_pkg::*;
#(
    parameter int NUM_COMPUTE_UNITS      = 4,
    parameter int TENSOR_DIMENSIONS      = 3,
    parameter int FACTOR_MATRIX_WIDTH    = 32,
    parameter int RANK_FACTOR_MATRIX     = 16,
    parameter int MODE_TENSOR_ADDR_WIDTH = 16,
    parameter int MAX_OUTSTANDING        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_COMPUTE_UNITS-1:0] req_en,
    input  logic [NUM_COMPUTE_UNITS-1:0][TENSOR_DIMENSIONS-2:0]
                 [MODE_TENSOR_ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_COMPUTE_UNITS-1:0] req_ready,
    output logic mem_addr_en,
    output logic [TENSOR_DIMENSIONS-2:0]
                 [MODE_TENSOR_ADDR_WIDTH-1:0] mem_addr,
    output logic [cid_width(NUM_COMPUTE_UNITS)-1:0] mem_compute_id,
    input  logic mem_addr_ready,
    input  logic mem_data_en,
    input  logic [TENSOR_DIMENSIONS-2:0][RANK_FACTOR_MATRIX-1:0]
                 [FACTOR_MATRIX_WIDTH-1:0] mem_data,
    output logic [NUM_COMPUTE_UNITS-1:0] resp_en,
    output logic [TENSOR_DIMENSIONS-2:0][RANK_FACTOR_MATRIX-1:0]
                 [FACTOR_MATRIX_WIDTH-1:0] resp_data,
    input  logic end_of_shard,
    output logic drain_done,
    output logic busy,
    output logic err_unexpected
`ifdef FETCH_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int NCU   = NUM_COMPUTE_UNITS;
    localparam int CID_W = cid_width(NCU);
    localparam int PTR_W = CID_W - 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       r_state;
    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_addr_en;
    logic [CID_W-1:0] r_cid;
    logic [NCU-1:0]   r_resp_en;
    logic             r_drain_done;
    logic             r_err;
    logic [TENSOR_DIMENSIONS-2:0][MODE_TENSOR_ADDR_WIDTH-1:0] r_addr;
    logic [TENSOR_DIMENSIONS-2:0][RANK_FACTOR_MATRIX-1:0]
          [FACTOR_MATRIX_WIDTH-1:0] r_resp_data;

    logic             w_found;
    logic [PTR_W-1:0] w_gnt;
    logic [NCU-1:0]   w_onehot;
    int               w_j;
    logic             w_hs;
    logic             w_pop;
    logic             w_accept;
    logic             w_slot_ok;
    logic             w_state_ok;
    logic             w_hold_next;
    logic             w_full;
    logic             w_empty;
    logic [CID_W-1:0] w_tag;
    logic [CNT_W-1:0] w_fifo_cnt;
    logic [CNT_W:0]   w_outstanding;
    logic [CNT_W:0]   w_cnt_next;

    // First requester at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_gnt    = '0;
        w_j      = 0;
        w_onehot = '0;
        for (int i = 0; i < NCU; i++) begin
            w_j = (int'(r_rr_ptr) + i) % NCU;
            if (!w_found && req_en[PTR_W'(w_j)]) begin
                w_found = 1'b1;
                w_gnt   = PTR_W'(w_j);
            end
        end
        w_onehot[w_gnt] = 1'b1;
    end

    assign w_hs          = r_addr_en & mem_addr_ready;
    assign w_pop         = mem_data_en & ~w_empty;
    assign w_hold_next   = r_addr_en & ~mem_addr_ready;
    // A held address counts as in flight so the FIFO can never overflow.
    assign w_outstanding = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, r_addr_en};
    assign w_cnt_next    = {1'b0, w_fifo_cnt} + {{CNT_W{1'b0}}, w_hs}
                         - {{CNT_W{1'b0}}, w_pop};
    assign w_slot_ok     = (w_outstanding < (CNT_W+1)'(MAX_OUTSTANDING))
                         & ~w_full;
    assign w_state_ok    = (r_state == IDLE)
                         | ((r_state == HOLD) & mem_addr_ready);
    assign w_accept      = rst & w_found & w_slot_ok & w_state_ok
                         & ~end_of_shard;

    assign req_ready      = w_accept ? w_onehot : '0;
    assign mem_addr_en    = r_addr_en;
    assign mem_addr       = r_addr;
    assign mem_compute_id = r_cid;
    assign resp_en        = r_resp_en;
    assign resp_data      = r_resp_data;
    assign drain_done     = r_drain_done;
    assign err_unexpected = r_err;
    assign busy           = (r_state != IDLE) | (w_fifo_cnt != '0);

    fetch_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (CID_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_hs),
        .din   (r_cid),
        .pop   (w_pop),
        .dout  (w_tag),
        .full  (w_full),
        .empty (w_empty),
        .count (w_fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_addr_en    <= 1'b0;
            r_addr       <= '0;
            r_cid        <= CID_W'(NCU);
            r_resp_en    <= '0;
            r_resp_data  <= '0;
            r_drain_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_drain_done <= 1'b0;
            if (w_accept) begin
                r_addr_en <= 1'b1;
                r_addr    <= req_addr[w_gnt];
                r_cid     <= CID_W'(w_gnt);
                r_rr_ptr  <= (w_gnt == PTR_W'(NCU - 1)) ? '0 : w_gnt + 1'b1;
            end else if (w_hs) begin
                r_addr_en <= 1'b0;
                r_cid     <= CID_W'(NCU);
            end
            if (end_of_shard) begin
                r_state <= DRAIN;
            end else begin
                unique case (r_state)
                    IDLE, HOLD: r_state <= (w_accept | w_hold_next) ? HOLD : IDLE;
                    DRAIN: begin
                        if (!w_hold_next && w_cnt_next == '0) begin
                            r_state      <= IDLE;
                            r_drain_done <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
            r_resp_en <= w_pop ? (NCU'(1) << w_tag) : '0;
            if (w_pop)
                r_resp_data <= mem_data;
            if (mem_data_en & w_empty)
                r_err <= 1'b1;
        end
    end

`ifdef FETCH_ARB_PERF_CNT_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_hs && r_perf_issue != '1)
                r_perf_issue <= r_perf_issue + 1'b1;
            if ((|req_en) && !w_accept && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_factor_fetch_arbiter.sv
// Directed self-checking bench for factor_fetch_arbiter.
// Covers round-robin, back-pressure, credit limit, tag routing, drain, errors.
module tb_factor_fetch_arbiter;

    localparam int NCU  = 4;
    localparam int DIM  = 3;
    localparam int FMW  = 32;
    localparam int RANK = 16;
    localparam int AW   = 16;
    localparam int MO   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                                rst;
    logic [NCU-1:0]                      req_en;
    logic [NCU-1:0][DIM-2:0][AW-1:0]     req_addr;
    logic [NCU-1:0]                      req_ready;
    logic                                mem_addr_en;
    logic [DIM-2:0][AW-1:0]              mem_addr;
    logic [2:0]                          mem_compute_id;
    logic                                mem_addr_ready;
    logic                                mem_data_en;
    logic [DIM-2:0][RANK-1:0][FMW-1:0]   mem_data;
    logic [NCU-1:0]                      resp_en;
    logic [DIM-2:0][RANK-1:0][FMW-1:0]   resp_data;
    logic                                end_of_shard;
    logic                                drain_done;
    logic                                busy;
    logic                                err_unexpected;
`ifdef FETCH_ARB_PERF_CNT_EN
    logic [31:0]                         perf_issue_cnt;
    logic [31:0]                         perf_stall_cnt;
`endif

    factor_fetch_arbiter #(
        .NUM_COMPUTE_UNITS      (NCU),
        .TENSOR_DIMENSIONS      (DIM),
        .FACTOR_MATRIX_WIDTH    (FMW),
        .RANK_FACTOR_MATRIX     (RANK),
        .MODE_TENSOR_ADDR_WIDTH (AW),
        .MAX_OUTSTANDING        (MO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_en         (req_en),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .mem_addr_en    (mem_addr_en),
        .mem_addr       (mem_addr),
        .mem_compute_id (mem_compute_id),
        .mem_addr_ready (mem_addr_ready),
        .mem_data_en    (mem_data_en),
        .mem_data       (mem_data),
        .resp_en        (resp_en),
        .resp_data      (resp_data),
        .end_of_shard   (end_of_shard),
        .drain_done     (drain_done),
        .busy           (busy),
        .err_unexpected (err_unexpected)
`ifdef FETCH_ARB_PERF_CNT_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        req_en         = '0;
        req_addr       = '0;
        mem_addr_ready = 1'b0;
        mem_data_en    = 1'b0;
        mem_data       = '0;
        end_of_shard   = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_cid [5] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

    initial begin
        // reset values, with requests asserted during reset
        do_reset();
        rst    = 1'b0;
        req_en = 4'b1111;
        tick();
        settle();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_addr_en", 64'(mem_addr_en), 64'h0);
        chk("rst_addr", 64'(mem_addr), 64'h0);
        chk("rst_cid", 64'(mem_compute_id), 64'd4);
        chk("rst_resp_en", 64'(resp_en), 64'h0);
        chk("rst_resp_data", 64'(resp_data[0][0]), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(err_unexpected), 64'h0);
        chk("rst_drain", 64'(drain_done), 64'h0);

        // round robin with all units requesting
        do_reset();
        req_en         = 4'b1111;
        mem_addr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            settle();
            chk($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(exp_rdy[i]));
            chk($sformatf("rr_cid%0d", i), 64'(mem_compute_id), 64'(exp_cid[i]));
        end

        // back-pressure holds the address stable
        do_reset();
        req_addr[2] = 32'h0012_0034;
        req_en      = 4'b0100;
        settle();
        chk("bp_accept", 64'(req_ready), 64'h4);
        tick();
        req_en = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            settle();
            chk($sformatf("bp_en%0d", i), 64'(mem_addr_en), 64'h1);
            chk($sformatf("bp_addr%0d", i), 64'(mem_addr), 64'h0012_0034);
            chk($sformatf("bp_cid%0d", i), 64'(mem_compute_id), 64'd2);
        end
        tick();
        mem_addr_ready = 1'b1;
        settle();
        chk("bp_hs_en", 64'(mem_addr_en), 64'h1);
        tick();
        mem_addr_ready = 1'b0;
        settle();
        chk("bp_after_en", 64'(mem_addr_en), 64'h0);
        chk("bp_after_cid", 64'(mem_compute_id), 64'd4);
        chk("bp_busy", 64'(busy), 64'h1);
        mem_data       = '0;
        mem_data[0][0] = 32'hCAFE_0001;
        mem_data[1][15] = 32'h5A5A_0002;
        mem_data_en    = 1'b1;
        tick();
        mem_data_en = 1'b0;
        settle();
        chk("bp_resp_en", 64'(resp_en), 64'h4);
        chk("bp_resp_lo", 64'(resp_data[0][0]), 64'hCAFE_0001);
        chk("bp_resp_hi", 64'(resp_data[1][15]), 64'h5A5A_0002);
        chk("bp_err", 64'(err_unexpected), 64'h0);
        tick();
        chk("bp_resp_off", 64'(resp_en), 64'h0);
        chk("bp_idle", 64'(busy), 64'h0);

        // outstanding limit
        do_reset();
        mem_addr_ready = 1'b1;
        req_en         = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("lim_ready%0d", k), 64'(req_ready),
                (k < MO) ? 64'h1 : 64'h0);
            tick();
        end
        mem_data_en = 1'b1;
        settle();
        chk("lim_prepop", 64'(req_ready), 64'h0);
        tick();
        mem_data_en = 1'b0;
        settle();
        chk("lim_reopen", 64'(req_ready), 64'h1);
        chk("lim_resp", 64'(resp_en), 64'h1);
        chk("lim_busy", 64'(busy), 64'h1);

        // mid-operation reset discards tags; a return then is unexpected
        do_reset();
        mem_data_en = 1'b1;
        tick();
        mem_data_en = 1'b0;
        settle();
        chk("unx_resp", 64'(resp_en), 64'h0);
        chk("unx_err", 64'(err_unexpected), 64'h1);
        chk("unx_busy", 64'(busy), 64'h0);
        tick();
        chk("unx_sticky", 64'(err_unexpected), 64'h1);
        rst = 1'b0;
        tick();
        chk("unx_clear", 64'(err_unexpected), 64'h0);
        rst = 1'b1;

        // in-order tag routing
        do_reset();
        mem_addr_ready = 1'b1;
        req_en         = 4'b0010;
        settle();
        chk("ord_acc1", 64'(req_ready), 64'h2);
        tick();
        req_en = 4'b1000;
        settle();
        chk("ord_acc3", 64'(req_ready), 64'h8);
        tick();
        req_en = 4'b0001;
        settle();
        chk("ord_acc0", 64'(req_ready), 64'h1);
        tick();
        req_en = '0;
        tick();
        mem_data       = '0;
        mem_data[0][0] = 32'hD1;
        mem_data_en    = 1'b1;
        settle();
        chk("ord_none", 64'(resp_en), 64'h0);
        tick();
        mem_data[0][0] = 32'hD2;
        settle();
        chk("ord_r1", 64'(resp_en), 64'h2);
        chk("ord_d1", 64'(resp_data[0][0]), 64'hD1);
        tick();
        mem_data[0][0] = 32'hD3;
        settle();
        chk("ord_r2", 64'(resp_en), 64'h8);
        chk("ord_d2", 64'(resp_data[0][0]), 64'hD2);
        tick();
        mem_data_en = 1'b0;
        settle();
        chk("ord_r3", 64'(resp_en), 64'h1);
        chk("ord_d3", 64'(resp_data[0][0]), 64'hD3);
        tick();
        chk("ord_off", 64'(resp_en), 64'h0);
        chk("ord_idle", 64'(busy), 64'h0);

        // drain with two fetches outstanding
        do_reset();
        mem_addr_ready = 1'b1;
        req_en         = 4'b0001;
        settle();
        chk("dr_acc0", 64'(req_ready), 64'h1);
        tick();
        req_en = 4'b0010;
        settle();
        chk("dr_acc1", 64'(req_ready), 64'h2);
        tick();
        req_en = '0;
        tick();
        end_of_shard = 1'b1;
        req_en       = 4'b1111;
        settle();
        chk("dr_eos_block", 64'(req_ready), 64'h0);
        tick();
        end_of_shard = 1'b0;
        settle();
        chk("dr_block", 64'(req_ready), 64'h0);
        chk("dr_done_early", 64'(drain_done), 64'h0);
        chk("dr_busy", 64'(busy), 64'h1);
        mem_data_en = 1'b1;
        tick();
        settle();
        chk("dr_done_mid", 64'(drain_done), 64'h0);
        chk("dr_resp0", 64'(resp_en), 64'h1);
        tick();
        mem_data_en = 1'b0;
        req_en      = '0;
        settle();
        chk("dr_done", 64'(drain_done), 64'h1);
        chk("dr_resp1", 64'(resp_en), 64'h2);
        chk("dr_idle", 64'(busy), 64'h0);
        tick();
        chk("dr_done_off", 64'(drain_done), 64'h0);
        req_en = 4'b0001;
        settle();
        chk("dr_reaccept", 64'(req_ready), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/factor_fetch_arbiter.md
FACTOR_FETCH_ARBITER -- requirements
Module: factor_fetch_arbiter

Interface
REQ-001 SHALL have parameter NUM_COMPUTE_UNITS, default 4, number of requesting compute units.
REQ-002 SHALL have parameter TENSOR_DIMENSIONS, default 3, tensor order; factor ports carry TENSOR_DIMENSIONS-1 modes.
REQ-003 SHALL have parameter FACTOR_MATRIX_WIDTH, default 32, factor element width.
REQ-004 SHALL have parameter RANK_FACTOR_MATRIX, default 16, elements per factor row.
REQ-005 SHALL have parameter MODE_TENSOR_ADDR_WIDTH, default 16, factor row address width.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 8, maximum issued-but-unreturned fetches.
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 reset, single clock domain, synchronous, active-low.
REQ-008 SHALL have ports: req_en in NCU, per-unit fetch request; req_addr in NCU x (DIM-1) x ADDR_W, per-unit row addresses; req_ready out NCU, one-hot accept pulse.
REQ-009 SHALL have ports: mem_addr_en out 1; mem_addr out (DIM-1) x ADDR_W; mem_compute_id out $clog2(NCU)+1; mem_addr_ready in 1.
REQ-010 SHALL have ports: mem_data_en in 1; mem_data in (DIM-1) x RANK x FMW; resp_en out NCU; resp_data out (DIM-1) x RANK x FMW.
REQ-011 SHALL have ports: end_of_shard in 1; drain_done out 1; busy out 1; err_unexpected out 1.

Function
REQ-012 SHALL implement states IDLE (no address held), HOLD (mem_addr_en=1, awaiting mem_addr_ready), DRAIN (shard closing).
REQ-013 SHALL accept a request only in IDLE, or in HOLD in the cycle mem_addr_ready=1, and only when outstanding count (pre-pop value) < MAX_OUTSTANDING.
REQ-014 SHALL select among asserted req_en round-robin, search starting at rr_ptr; after accepting unit g, rr_ptr = (g+1) mod NCU.
REQ-015 SHALL pulse req_ready[g] combinationally in the accept cycle; mem_addr/mem_compute_id register req_addr[g]/g and mem_addr_en=1 next cycle (latency 1, throughput 1/cycle).
REQ-016 SHALL hold mem_addr and mem_compute_id stable while mem_addr_en=1 and mem_addr_ready=0; mem_compute_id = NCU when mem_addr_en=0.
REQ-017 SHALL push the compute id into an in-order tag FIFO (depth MAX_OUTSTANDING) on each mem_addr_en&mem_addr_ready handshake.
REQ-018 SHALL, on mem_data_en with FIFO non-empty, pop the tag and register resp_en[tag]=1 (one-hot) and resp_data=mem_data the next cycle, for one cycle.
REQ-019 SHALL ignore mem_data_en with FIFO empty and set sticky err_unexpected=1 (cleared only by reset).
REQ-020 SHALL leave outstanding count unchanged on simultaneous push and pop.
REQ-021 SHALL enter DRAIN on end_of_shard=1 from any state; in DRAIN no req_ready, held address still completes its handshake.
REQ-022 SHALL, in DRAIN, when no address held and outstanding=0, pulse drain_done for one cycle and return to IDLE.
REQ-023 SHALL drive busy=1 whenever state!=IDLE or outstanding!=0.

Reset
REQ-024 SHALL, while rst=0 at a clk edge: state IDLE, rr_ptr 0, FIFO empty, outstanding 0, mem_addr_en 0, mem_addr 0, mem_compute_id NCU, resp_en 0, resp_data 0, drain_done 0, err_unexpected 0, busy 0; req_ready 0 while rst=0.
REQ-025 SHALL discard outstanding tags on mid-operation reset; returns after reset are handled per REQ-019.

Configuration
REQ-026 SHALL, with FETCH_ARB_PERF_CNT_EN defined, add outputs perf_issue_cnt (32b, handshakes) and perf_stall_cnt (32b, cycles any req_en=1 but none accepted), saturating, reset to 0.
REQ-027 SHALL, without FETCH_ARB_PERF_CNT_EN, omit those ports and counters entirely.

Structure
REQ-028 SHALL place the state enum (IDLE/HOLD/DRAIN) and compute-id width function in shared package mttkrp_pkg.
REQ-029 SHALL implement the tag FIFO as sub-module fetch_tag_fifo (push, pop, full, empty, count).

Verification
REQ-030 SHALL cover: req_en=4'b1111 held, mem_addr_ready=1 -> req_ready order 0,1,2,3,0, one per cycle.
REQ-031 SHALL cover: unit 2 request addr {0x0012,0x0034}, mem_addr_ready=0 for 3 cycles -> mem_addr_en and values held 3 cycles, one handshake, mem_compute_id=2.
REQ-032 SHALL cover: 8 issues with no returns -> 9th request not accepted; one mem_data_en -> next request accepted the following cycle.
REQ-033 SHALL cover: issue ids 1,3,0 then three mem_data_en -> resp_en 4'b0010, 4'b1000, 4'b0001 in order, each 1 cycle after its return.
REQ-034 SHALL cover: end_of_shard with 2 outstanding -> no req_ready, drain_done one-cycle pulse the cycle after last return, then state IDLE.
REQ-035 SHALL cover: mem_data_en with empty FIFO -> no resp_en, err_unexpected=1 until rst=0.
